jt9346_host: RTL and testbench

//  Host-side initiator for 93C46/96C06-style 3-wire serial EEPROMs (jt9346 or real part).

---
 rtl/jt9346_host_pkg.sv | 51 +++++
 rtl/jt9346_host_div.sv | 38 +++
 rtl/jt9346_host.sv | 178 +++++++++++++++++
 tb/tb_jt9346_host.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/jt9346_host_pkg.sv
// Shared constants for the jt9346 host: command codes, serial opcodes and FSM states.
// Used by jt9346_host (optional ready-poll timeout: JT9346_HOST_TIMEOUT_EN).
package jt9346_host_pkg;

    localparam logic [2:0] OP_READ  = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_ERASE = 3'd2;
    localparam logic [2:0] OP_EWEN  = 3'd3;
    localparam logic [2:0] OP_EWDS  = 3'd4;
    localparam logic [2:0] OP_ERAL  = 3'd5;
    localparam logic [2:0] OP_WRAL  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    localparam logic [1:0] SOP_READ  = 2'b10;
    localparam logic [1:0] SOP_WRITE = 2'b01;
    localparam logic [1:0] SOP_ERASE = 2'b11;
    localparam logic [1:0] SOP_EXT   = 2'b00;

    localparam logic [1:0] EXT_EWEN = 2'b11;
    localparam logic [1:0] EXT_EWDS = 2'b00;
    localparam logic [1:0] EXT_ERAL = 2'b10;
    localparam logic [1:0] EXT_WRAL = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_CMD, ST_WDATA, ST_RDATA, ST_CSLOW, ST_POLL, ST_DONE
    } state_e;

    // {serial opcode, two address MSBs used by the extended (00) opcode group}
    function automatic logic [3:0] op_code(input logic [2:0] op);
        case (op)
            OP_READ:  return {SOP_READ,  2'b00};
            OP_WRITE: return {SOP_WRITE, 2'b00};
            OP_ERASE: return {SOP_ERASE, 2'b00};
            OP_EWEN:  return {SOP_EXT,   EXT_EWEN};
            OP_EWDS:  return {SOP_EXT,   EXT_EWDS};
            OP_ERAL:  return {SOP_EXT,   EXT_ERAL};
            OP_WRAL:  return {SOP_EXT,   EXT_WRAL};
            default:  return 4'b0000;
        endcase
    endfunction

    function automatic logic is_ext_op(input logic [2:0] op);
        return op inside {OP_EWEN, OP_EWDS, OP_ERAL, OP_WRAL};
    endfunction

    // Commands that program the array and therefore need a ready/busy poll
    function automatic logic is_poll_op(input logic [2:0] op);
        return op inside {OP_WRITE, OP_ERASE, OP_ERAL, OP_WRAL};
    endfunction

endpackage

// File: rtl/jt9346_host_div.sv
// Serial clock divider: a tick every CLKDIV clk cycles, alternating rise/fall strobes.
// Counter and phase are held cleared while i_en is low.
module jt9346_host_div #(
    parameter int unsigned CLKDIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_rise_c,
    output logic o_fall_c
);

    localparam int unsigned CW = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_ph;
    logic          w_tick;

    assign w_tick   = i_en && (r_cnt == CW'(CLKDIV - 1));
    assign o_rise_c = w_tick && !r_ph;
    assign o_fall_c = w_tick &&  r_ph;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_ph  <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_ph  <= 1'b0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_ph  <= ~r_ph;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/jt9346_host.sv
// Host initiator for 93C46/96C06-style 3-wire EEPROMs: one parallel command -> one serial frame.
// Optional macro JT9346_HOST_TIMEOUT_EN bounds the ready poll to TOUT clk cycles.
module jt9346_host
    import jt9346_host_pkg::*;
#(
    parameter  int unsigned DW     = 16,
    parameter  int unsigned CLKDIV = 4,
    parameter  int unsigned TOUT   = 4096,
    localparam int unsigned AW     = (DW == 16) ? 6 : 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [2:0]    op,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          ee_sclk,
    output logic          ee_sdi,
    output logic          ee_scs,
    input  logic          ee_sdo
);

    localparam int unsigned FW = 2 + AW + DW;
    localparam int unsigned NW = $clog2(DW + 2);

    if (CLKDIV < 2 || TOUT == 0) begin : g_bad_param
        $error("jt9346_host: CLKDIV must be >= 2 and TOUT > 0");
    end

    state_e        r_state;
    logic [2:0]    r_op;
    logic [FW-1:0] r_sh;
    logic [NW-1:0] r_nbit;
    logic [DW-1:0] r_rsh;
`ifdef JT9346_HOST_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TOUT + 1);
    logic [TW-1:0] r_tcnt;
`endif

    logic          w_rise;
    logic          w_fall;
    logic [3:0]    w_code;
    logic [AW-1:0] w_af;
    logic [DW-1:0] w_wd;

    jt9346_host_div #(.CLKDIV(CLKDIV)) u_div (
        .clk     (clk),
        .rst     (rst),
        .i_en    (r_state != ST_IDLE),
        .o_rise_c(w_rise),
        .o_fall_c(w_fall)
    );

    // Frame after the start bit: opcode, address field, data (zeros shift out during READ)
    assign w_code = op_code(op);
    assign w_af   = is_ext_op(op) ? {w_code[1:0], (AW-2)'(0)} : addr;
    assign w_wd   = (op == OP_WRITE || op == OP_WRAL) ? wdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_sh    <= '0;
            r_nbit  <= '0;
            r_rsh   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            ee_sclk <= 1'b0;
            ee_sdi  <= 1'b0;
            ee_scs  <= 1'b0;
`ifdef JT9346_HOST_TIMEOUT_EN
            r_tcnt  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: if (req) begin
                    r_op <= op;
                    err  <= 1'b0;
                    if (op == OP_RSVD) begin
                        done    <= 1'b1;
                        err     <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        busy    <= 1'b1;
                        ee_scs  <= 1'b1;
                        ee_sdi  <= 1'b1;
                        r_sh    <= {w_code[3:2], w_af, w_wd};
                        r_nbit  <= '0;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: if (w_rise) begin
                    ee_sclk <= 1'b1;
                    r_nbit  <= NW'(1);
                    r_state <= ST_CMD;
                end
                ST_CMD, ST_WDATA, ST_RDATA: begin
                    if (w_rise) begin
                        ee_sclk <= 1'b1;
                        r_nbit  <= r_nbit + 1'b1;
                    end else if (w_fall) begin
                        ee_sclk <= 1'b0;
                        ee_sdi  <= r_sh[FW-1];
                        r_sh    <= r_sh << 1;
                        if (r_state == ST_CMD && r_nbit == NW'(3 + AW)) begin
                            r_nbit <= '0;
                            case (r_op)
                                OP_READ:           r_state <= ST_RDATA;
                                OP_WRITE, OP_WRAL: r_state <= ST_WDATA;
                                default: begin
                                    ee_scs  <= 1'b0;
                                    ee_sdi  <= 1'b0;
                                    r_state <= ST_CSLOW;
                                end
                            endcase
                        end else if (r_state == ST_WDATA && r_nbit == NW'(DW)) begin
                            ee_scs  <= 1'b0;
                            ee_sdi  <= 1'b0;
                            r_state <= ST_CSLOW;
                        end else if (r_state == ST_RDATA) begin
                            // last rise only clocks the EEPROM out of its read
                            if (r_nbit == NW'(DW + 1)) begin
                                ee_scs  <= 1'b0;
                                ee_sdi  <= 1'b0;
                                r_state <= ST_CSLOW;
                            end else begin
                                r_rsh <= {r_rsh[DW-2:0], ee_sdo};
                            end
                        end
                    end
                end
                ST_CSLOW: if (w_fall) begin
                    if (is_poll_op(r_op)) begin
                        ee_scs  <= 1'b1;
                        r_state <= ST_POLL;
`ifdef JT9346_HOST_TIMEOUT_EN
                        r_tcnt  <= '0;
`endif
                    end else begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_DONE;
                        if (r_op == OP_READ) rdata <= r_rsh;
                    end
                end
                ST_POLL: begin
                    if (ee_sdo) begin
                        ee_scs  <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_DONE;
                    end
`ifdef JT9346_HOST_TIMEOUT_EN
                    else if (r_tcnt == TW'(TOUT - 1)) begin
                        ee_scs  <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
`endif
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jt9346_host.sv
// Directed bench for jt9346_host against a small behavioural 93C46 (x16) model.
// Timeout section is active only when JT9346_HOST_TIMEOUT_EN is defined.
module tb_jt9346_host;

    localparam logic [2:0] L_READ  = 3'd0;
    localparam logic [2:0] L_WRITE = 3'd1;
    localparam logic [2:0] L_EWEN  = 3'd3;
    localparam logic [2:0] L_EWDS  = 3'd4;
    localparam logic [2:0] L_ERAL  = 3'd5;
    localparam logic [2:0] L_WRAL  = 3'd6;
    localparam logic [2:0] L_RSVD  = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [2:0]  op = '0;
    logic [5:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic        busy, done, err, ee_sclk, ee_sdi, ee_scs, ee_sdo;
    logic [15:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    logic scs_seen, poll_seen;

    always #5 clk = ~clk;

    jt9346_host #(.DW(16), .CLKDIV(4), .TOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .err(err),
        .ee_sclk(ee_sclk), .ee_sdi(ee_sdi), .ee_scs(ee_scs), .ee_sdo(ee_sdo)
    );

    // Behavioural EEPROM: powers up erased and write-disabled
    logic [15:0] mem [64] = '{default: 16'hFFFF};
    logic        m_ewen = 1'b0, m_started = 1'b0, m_sdo = 1'b1;
    logic        m_wr_tog = 1'b0, m_wr_seen = 1'b0, m_stuck = 1'b0;
    logic [7:0]  m_cmd = '0;
    logic [15:0] m_data = '0;
    int          m_cnt = 0;
    int          m_busy = 0;

    always @(posedge ee_sclk or negedge ee_scs) begin
        logic did;
        logic [3:0] bi;
        did = 1'b0;
        if (!ee_scs) begin
            if (m_started && m_cnt >= 8) begin
                case (m_cmd[7:6])
                    2'b00: case (m_cmd[5:4])
                        2'b11: m_ewen = 1'b1;
                        2'b00: m_ewen = 1'b0;
                        2'b10: if (m_ewen) begin
                            for (int i = 0; i < 64; i++) mem[6'(i)] = 16'hFFFF;
                            did = 1'b1;
                        end
                        default: if (m_ewen && m_cnt == 24) begin
                            for (int i = 0; i < 64; i++) mem[6'(i)] = m_data;
                            did = 1'b1;
                        end
                    endcase
                    2'b01: if (m_ewen && m_cnt == 24) begin
                        mem[m_cmd[5:0]] = m_data;
                        did = 1'b1;
                    end
                    2'b11: if (m_ewen) begin
                        mem[m_cmd[5:0]] = 16'hFFFF;
                        did = 1'b1;
                    end
                    default: ;
                endcase
                if (did) m_wr_tog = ~m_wr_tog;
            end
            m_started = 1'b0;
            m_cnt     = 0;
            m_sdo     = 1'b1;
        end else if (!m_started) begin
            m_started = ee_sdi;
        end else if (m_cnt < 8) begin
            m_cmd = {m_cmd[6:0], ee_sdi};
            m_cnt++;
            if (m_cnt == 8 && m_cmd[7:6] == 2'b10) m_sdo = 1'b0;
        end else if (m_cmd[7:6] == 2'b10) begin
            if (m_cnt < 24) begin
                bi = 4'(23 - m_cnt);
                m_sdo = mem[m_cmd[5:0]][bi];
            end
            m_cnt++;
        end else if (m_cnt < 24) begin
            m_data = {m_data[14:0], ee_sdi};
            m_cnt++;
        end
    end

    // Programming keeps the ready line low for 20 clk cycles after chip select drops
    always @(posedge clk) begin
        if (m_wr_tog != m_wr_seen) begin
            m_wr_seen <= m_wr_tog;
            m_busy    <= 20;
        end else if (m_busy != 0) begin
            m_busy <= m_busy - 1;
        end
    end

    assign ee_sdo = (m_stuck || m_busy != 0 || m_wr_tog != m_wr_seen) ? 1'b0 : m_sdo;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input logic [2:0] c_op, input logic [5:0] c_addr,
                           input logic [15:0] c_wd, input bit noise);
        int n;
        @(negedge clk);
        op = c_op; addr = c_addr; wdata = c_wd; req = 1'b1;
        scs_seen = 1'b0; poll_seen = 1'b0;
        @(negedge clk);
        req = 1'b0;
        n = 1;
        while (!done && n < 20000) begin
            if (ee_scs) scs_seen = 1'b1;
            if (ee_scs && m_busy != 0) poll_seen = 1'b1;
            req = noise && (n % 40 == 20);
            if (req) begin op = L_WRITE; wdata = 16'h0000; end
            @(negedge clk);
            n++;
        end
        req = 1'b0;
        lat = n;
        chk("cmd_done", 32'(done), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ctl", 32'({busy, done, err, ee_scs, ee_sclk, ee_sdi}), 0);
        chk("rst_rdata", 32'(rdata), 0);

        run_cmd(L_READ, 6'h00, 16'h0, 1'b0);
        chk("rd0_data", 32'(rdata), 32'hFFFF);
        chk("rd0_err", 32'(err), 0);
        chk("rd0_lat", 32'(lat), 217);
        @(negedge clk);
        chk("done_pulse", 32'({done, busy}), 0);

        run_cmd(L_EWEN, 6'h00, 16'h0, 1'b0);
        run_cmd(L_WRITE, 6'h2A, 16'hA5C3, 1'b0);
        chk("wr_poll", 32'(poll_seen), 1);
        chk("wr_rdata_held", 32'(rdata), 32'hFFFF);
        run_cmd(L_READ, 6'h2A, 16'h0, 1'b0);
        chk("rd2a", 32'(rdata), 32'hA5C3);

        run_cmd(L_WRAL, 6'h00, 16'h1234, 1'b0);
        run_cmd(L_READ, 6'h3F, 16'h0, 1'b0);
        chk("wral_3f", 32'(rdata), 32'h1234);
        run_cmd(L_READ, 6'h00, 16'h0, 1'b0);
        chk("wral_00", 32'(rdata), 32'h1234);

        run_cmd(L_ERAL, 6'h00, 16'h0, 1'b0);
        run_cmd(L_READ, 6'h10, 16'h0, 1'b0);
        chk("eral_10", 32'(rdata), 32'hFFFF);

        run_cmd(L_EWDS, 6'h00, 16'h0, 1'b0);
        run_cmd(L_WRITE, 6'h10, 16'h0001, 1'b0);
        run_cmd(L_READ, 6'h10, 16'h0, 1'b0);
        chk("ewds_wr_blocked", 32'(rdata), 32'hFFFF);

        run_cmd(L_EWEN, 6'h00, 16'h0, 1'b0);
        run_cmd(L_WRITE, 6'h10, 16'h0001, 1'b0);
        run_cmd(L_EWDS, 6'h00, 16'h0, 1'b0);
        run_cmd(L_ERAL, 6'h00, 16'h0, 1'b0);
        run_cmd(L_READ, 6'h10, 16'h0, 1'b0);
        chk("ewds_eral_blocked", 32'(rdata), 32'h0001);
        run_cmd(L_READ, 6'h2A, 16'h0, 1'b0);
        chk("rd2a_erased", 32'(rdata), 32'hFFFF);

        run_cmd(L_RSVD, 6'h00, 16'h0, 1'b0);
        chk("rsvd_lat", 32'(lat), 1);
        chk("rsvd_err_scs", 32'({err, ee_scs, scs_seen}), 32'b100);

        run_cmd(L_READ, 6'h10, 16'h0, 1'b1);
        chk("noise_data", 32'(rdata), 32'h0001);
        chk("noise_err", 32'(err), 0);
        repeat (2) @(negedge clk);
        chk("noise_not_queued", 32'({busy, done}), 0);

`ifdef JT9346_HOST_TIMEOUT_EN
        run_cmd(L_EWEN, 6'h00, 16'h0, 1'b0);
        m_stuck = 1'b1;
        run_cmd(L_WRITE, 6'h3F, 16'h5555, 1'b0);
        chk("to_err", 32'(err), 1);
        chk("to_lat", 32'(lat), 273);
        m_stuck = 1'b0;
        repeat (30) @(negedge clk);
`endif

        run_cmd(L_EWEN, 6'h00, 16'h0, 1'b0);
        @(negedge clk);
        op = L_WRITE; addr = 6'h05; wdata = 16'hBEEF; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (120) @(negedge clk);
        chk("wd_active", 32'({busy, ee_scs}), 32'b11);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ctl", 32'({busy, done, err, ee_scs, ee_sclk, ee_sdi}), 0);
        chk("rst_mid_rdata", 32'(rdata), 0);
        @(negedge clk);
        rst = 1'b0;
        run_cmd(L_READ, 6'h05, 16'h0, 1'b0);
        chk("rd_after_rst", 32'(rdata), 32'hFFFF);
        run_cmd(L_READ, 6'h10, 16'h0, 1'b0);
        chk("rd10_after_rst", 32'(rdata), 32'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
